// File: rtl/dma_pkg.sv
//------------------------------------------------------------------------------
// Module      : dma_pkg
// Description : Shared types and constants for the DMA channel controller.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_XFER  = 3'd2,
        ST_IOSVC = 3'd3,
        ST_REL   = 3'd4
    } dma_state_t;

    localparam int DESC_W   = 26;
    localparam int OP_MSB   = 25;
    localparam int OP_LSB   = 24;
    localparam int TYPE_MSB = 23;
    localparam int TYPE_LSB = 22;
    localparam int SRC_MSB  = 21;
    localparam int SRC_LSB  = 14;
    localparam int DST_MSB  = 13;
    localparam int DST_LSB  = 6;
    localparam int CNT_MSB  = 5;
    localparam int CNT_LSB  = 0;

    localparam logic [1:0] OP_IO2MEM  = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] TYPE_IO    = 2'b01;
    localparam logic [1:0] TYPE_M2M   = 2'b10;
    localparam logic [1:0] OP_IOSVC   = 2'b11;
    localparam logic [1:0] TYPE_IOSVC = 2'b00;

    localparam logic [7:0] IO1_BASE = 8'd192;
    localparam logic [7:0] IO1_TOP  = 8'd223;
    localparam logic [7:0] IO2_BASE = 8'd224;
    localparam logic [7:0] IO2_TOP  = 8'd255;

    // I/O service word: the destination field carries the landing address.
    function automatic logic [DESC_W-1:0] io_word(input logic [7:0] fe);
        return {OP_IOSVC, TYPE_IOSVC, 8'd0, fe, 6'd0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_desc_fifo.sv
//------------------------------------------------------------------------------
// Module      : dma_desc_fifo
// Description : Show-ahead synchronous descriptor FIFO.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dma_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_data    = r_mem[r_rptr];
    // A full queue still accepts a write when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_channel_ctrl.sv
//------------------------------------------------------------------------------
// Module      : dma_channel_ctrl
// Description : Descriptor queue, bus arbitration and word sequencing for DMA.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dma_channel_ctrl #(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] FE_BASE = 8'd128,
    parameter logic [7:0] FE_TOP  = 8'd191
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [25:0] cmd,
    output logic        cmd_ready,
    input  logic        IOIP1,
    input  logic        IOIP2,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        grant,
    output logic [25:0] instruction,
    output logic [7:0]  next_source,
    output logic [7:0]  next_destination,
    output logic [7:0]  firstempty,
    output logic        busy,
    output logic        done,
    output logic        drop
);

    import dma_pkg::*;

    dma_state_t        r_state;
    logic [19:0]       r_hdr;
    logic [7:0]        r_src;
    logic [7:0]        r_dst;
    logic [5:0]        r_rem;
    logic              r_io_mode;

    logic [DESC_W-1:0] w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_io_req;
    logic [7:0]        w_fe_next;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_io_req  = IOIP1 || IOIP2;
    assign w_fe_next = (firstempty == FE_TOP) ? FE_BASE : firstempty + 8'd1;

    dma_desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DESC_W)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_hdr            <= '0;
            r_src            <= '0;
            r_dst            <= '0;
            r_rem            <= '0;
            r_io_mode        <= 1'b0;
            bus_req          <= 1'b0;
            grant            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            drop             <= 1'b0;
            instruction      <= '0;
            next_source      <= '0;
            next_destination <= '0;
            firstempty       <= FE_BASE;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_head[CNT_MSB:CNT_LSB] == 6'd0) begin
                            drop <= 1'b1;
                        end else begin
                            r_hdr     <= w_head[OP_MSB:DST_LSB];
                            r_src     <= w_head[SRC_MSB:SRC_LSB];
                            r_dst     <= w_head[DST_MSB:DST_LSB];
                            r_rem     <= w_head[CNT_MSB:CNT_LSB];
                            r_io_mode <= 1'b0;
                            busy      <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    // An arriving descriptor outranks a simultaneous I/O request.
                    end else if (w_io_req && !w_push) begin
                        r_io_mode <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ, ST_XFER, ST_IOSVC: begin
                    bus_req <= 1'b1;
                    if (!bus_grant) begin
                        grant   <= 1'b0;
                        r_state <= ST_REQ;
                    end else if (r_io_mode) begin
                        if (w_io_req) begin
                            grant       <= 1'b1;
                            firstempty  <= w_fe_next;
                            instruction <= io_word(w_fe_next);
                            r_state     <= ST_IOSVC;
                        end else begin
                            grant   <= 1'b0;
                            bus_req <= 1'b0;
                            r_state <= ST_REL;
                        end
                    end else if (r_rem == 6'd0) begin
                        grant   <= 1'b0;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_REL;
                    end else begin
                        // r_src/r_dst/r_rem always describe the next word to issue.
                        grant            <= 1'b1;
                        instruction      <= {r_hdr, r_rem};
                        next_source      <= r_src;
                        next_destination <= r_dst;
                        r_src            <= r_src + 8'd1;
                        r_dst            <= r_dst + 8'd1;
                        r_rem            <= r_rem - 6'd1;
                        r_state          <= ST_XFER;
                    end
                end
                ST_REL: begin
                    bus_req <= 1'b0;
                    grant   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
